mips_mem_arbiter: RTL and testbench

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/mips_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory arbiter: FSM states, requester ids
// and default bus widths.
package mips_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (if) and data (dm),
// data-priority with a starvation bound. Optional grant counters: MIPS_ARB_STATS_EN.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MIPS_ARB_STATS_EN
  ,
  output logic [15:0]       if_grant_cnt,
  output logic [15:0]       dm_grant_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] WAIT_INIT  = (MEM_LAT >= 2) ? 4'(MEM_LAT - 2) : 4'd0;

  arb_state_t state;
  req_id_t    owner;
  logic       lat_we;
  logic [3:0] starve_cnt;
  logic [3:0] wait_cnt;
  logic       pick_if;
  logic       grant_if;
  logic       grant_dm;
  logic       capture;

  // mem_rdata is valid on the edge that leaves WAIT, or leaves ISSUE when MEM_LAT is 1.
  always_comb begin
    pick_if  = if_req && (!dm_req || (starve_cnt == STARVE_LIM));
    grant_if = (state == IDLE) && pick_if;
    grant_dm = (state == IDLE) && dm_req && !pick_if;
    capture  = ((state == ISSUE) && !lat_we && (MEM_LAT == 1)) ||
               ((state == WAIT) && (wait_cnt == '0));
  end

  // mem_addr/mem_wdata double as the latched request; mem_we is kept separate
  // in lat_we because the output must drop after ISSUE.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= REQ_IF;
      lat_we     <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_if) begin
            owner      <= REQ_IF;
            lat_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= '0;
          end else if (grant_dm) begin
            owner     <= REQ_DM;
            lat_we    <= dm_we;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && (starve_cnt != STARVE_LIM))
              starve_cnt <= starve_cnt + 4'd1;
          end
          if (grant_if || grant_dm) begin
            state  <= ISSUE;
            mem_en <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_INIT;
          if (lat_we) begin
            state  <= RESP;
            dm_ack <= 1'b1;
          end else if (MEM_LAT == 1) begin
            state <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= RESP;
          else                wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (capture) begin
        if (owner == REQ_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_ack   <= 1'b1;
          dm_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef MIPS_ARB_STATS_EN
  always_ff @(posedge clk1) begin
    if (rst) begin
      if_grant_cnt <= '0;
      dm_grant_cnt <= '0;
    end else begin
      if (grant_if && (if_grant_cnt != '1)) if_grant_cnt <= if_grant_cnt + 16'd1;
      if (grant_dm && (dm_grant_cnt != '1)) dm_grant_cnt <= dm_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: requester tasks push expected acks,
// a negedge monitor pops and compares. Grant counters checked when MIPS_ARB_STATS_EN is set.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
`ifdef MIPS_ARB_STATS_EN
  logic [15:0]   if_grant_cnt;
  logic [15:0]   dm_grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic          who;
    logic [DW-1:0] data;
    int            exp_cyc;
  } exp_t;
  exp_t sbq[$];

  mips_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MIPS_ARB_STATS_EN
    ,
    .if_grant_cnt(if_grant_cnt), .dm_grant_cnt(dm_grant_cnt)
`endif
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  // Memory with 2-cycle read latency: data valid two edges after mem_en is raised.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic who, input logic [DW-1:0] data, input int exp_cyc);
    exp_t e;
    e.who = who; e.data = data; e.exp_cyc = exp_cyc;
    sbq.push_back(e);
  endtask

  task automatic if_access(input logic [AW-1:0] a);
    int n = 0;
    if_addr = a;
    if_req  = 1'b1;
    @(negedge clk1);
    while (!if_ack && n < 40) begin
      @(negedge clk1);
      n++;
    end
    chk("if_ack_timeout", {63'd0, if_ack}, 64'd1);
    @(posedge clk1);
    #1 if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int n = 0;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    dm_req   = 1'b1;
    @(negedge clk1);
    while (!dm_ack && n < 40) begin
      @(negedge clk1);
      n++;
    end
    chk("dm_ack_timeout", {63'd0, dm_ack}, 64'd1);
    @(posedge clk1);
    #1 dm_req = 1'b0;
  endtask

  exp_t          em;
  logic          got_who;
  logic [DW-1:0] got_d;
  always @(negedge clk1) begin
    if (!rst && (if_ack || dm_ack)) begin
      checks++;
      got_who = dm_ack;
      got_d   = dm_ack ? dm_rdata : if_rdata;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: got if_ack=%0b dm_ack=%0b at cyc %0d, expected none", if_ack, dm_ack, cyc);
      end else begin
        em = sbq.pop_front();
        if ((if_ack && dm_ack) || got_who != em.who || got_d !== em.data ||
            (em.exp_cyc >= 0 && cyc != em.exp_cyc)) begin
          errors++;
          $display("FAIL ack_cmp: got who=%0d data=%h cyc=%0d, expected who=%0d data=%h cyc=%0d",
                   got_who, got_d, cyc, em.who, em.data, em.exp_cyc);
        end
      end
    end
    checks++;
    if (mem_we && !mem_en) begin
      errors++;
      $display("FAIL mem_we_unqualified: got mem_we=1 mem_en=0 at cyc %0d, expected mem_we=0", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    mem[5] <= 32'h2000_0007;
    mem[9] <= 32'h0900_00A5;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk("rst_if_ack", {63'd0, if_ack}, 64'd0);
    chk("rst_dm_ack", {63'd0, dm_ack}, 64'd0);
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_busy",   {63'd0, busy},   64'd0);
    chk("rst_if_rdata",  64'(if_rdata),  64'd0);
    chk("rst_dm_rdata",  64'(dm_rdata),  64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk1);
    #1 rst = 1'b0;
    @(posedge clk1);
    #1;

    // Single fetch: mem_en one edge after sampling, ack with data MEM_LAT+1 edges after.
    k = cyc;
    push(REQ_IF, 32'h2000_0007, k + 3);
    fork
      if_access(10'd5);
      begin
        @(negedge clk1);
        chk("mem_en_in_idle", {63'd0, mem_en}, 64'd0);
        @(negedge clk1);
        chk("mem_en_issue", {63'd0, mem_en}, 64'd1);
        chk("mem_addr_issue", 64'(mem_addr), 64'd5);
        chk("mem_we_fetch", {63'd0, mem_we}, 64'd0);
        chk("busy_issue", {63'd0, busy}, 64'd1);
      end
    join

    // Simultaneous requests: dm read first, fetch ack 4 edges after dm ack.
    k = cyc;
    push(REQ_DM, 32'h0900_00A5, k + 3);
    push(REQ_IF, 32'h2000_0007, k + 7);
    fork
      if_access(10'd5);
      dm_access(1'b0, 10'd9, '0);
    join

    // Write to the top address leaves dm_rdata alone; read returns the written word.
    k = cyc;
    push(REQ_DM, 32'h0900_00A5, k + 2);
    fork
      dm_access(1'b1, 10'd1023, 32'hDEAD_BEEF);
      begin
        @(negedge clk1);
        @(negedge clk1);
        chk("mem_we_write", {63'd0, mem_we}, 64'd1);
        chk("mem_wdata_write", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("mem_addr_write", 64'(mem_addr), 64'd1023);
      end
    join
    push(REQ_DM, 32'hDEAD_BEEF, -1);
    dm_access(1'b0, 10'd1023, '0);

    // Starvation bound: four dm grants, then the waiting fetch, then dm resumes.
    push(REQ_DM, 32'hA5A5_0014, -1);
    push(REQ_DM, 32'hA5A5_0015, -1);
    push(REQ_DM, 32'hA5A5_0016, -1);
    push(REQ_DM, 32'hA5A5_0017, -1);
    push(REQ_IF, 32'hA5A5_001E, -1);
    push(REQ_DM, 32'hA5A5_0018, -1);
    push(REQ_DM, 32'hA5A5_0019, -1);
    fork
      if_access(10'd30);
      begin
        for (int a = 20; a < 26; a++) dm_access(1'b0, 10'(a), '0);
      end
    join
    chk("starve_cnt_clear", 64'(dut.starve_cnt), 64'd0);

    // Reset during WAIT abandons the read.
    dm_we = 1'b0; dm_addr = 10'd9; dm_req = 1'b1;
    @(posedge clk1);
    @(posedge clk1);
    @(negedge clk1);
    chk("busy_in_wait", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    dm_req = 1'b0;
    @(negedge clk1);
    chk("rst_wait_busy", {63'd0, busy}, 64'd0);
    chk("rst_wait_ack", {63'd0, dm_ack}, 64'd0);
    chk("rst_wait_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_wait_dm_rdata", 64'(dm_rdata), 64'd0);
    @(negedge clk1);
    chk("rst_wait_ack2", {63'd0, dm_ack}, 64'd0);
    chk("rst_wait_mem_en2", {63'd0, mem_en}, 64'd0);
    @(posedge clk1);
    #1 rst = 1'b0;
    push(REQ_DM, 32'h0900_00A5, -1);
    dm_access(1'b0, 10'd9, '0);

`ifdef MIPS_ARB_STATS_EN
    @(negedge clk1);
    rst = 1'b1;
    @(posedge clk1);
    #1 rst = 1'b0;
    push(REQ_IF, 32'h2000_0007, -1);
    if_access(10'd5);
    push(REQ_DM, 32'h0900_00A5, -1);
    dm_access(1'b0, 10'd9, '0);
    push(REQ_IF, 32'hA5A5_0001, -1);
    if_access(10'd1);
    push(REQ_DM, 32'h0900_00A5, -1);
    dm_access(1'b1, 10'd2, 32'h1234_5678);
    push(REQ_IF, 32'h1234_5678, -1);
    if_access(10'd2);
    @(negedge clk1);
    chk("if_grant_cnt", 64'(if_grant_cnt), 64'd3);
    chk("dm_grant_cnt", 64'(dm_grant_cnt), 64'd2);
`endif

    repeat (3) @(negedge clk1);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
